prime_checker_seq: RTL and testbench

//  Sequential, parametrised primality tester: the multi-cycle, N-bit generalisation of the
//  4-bit lookup prime detector. Accepts an unsigned operand on a start/busy handshake and

---
 rtl/prime_checker_seq.sv | 156 +++++++++++++++
 tb/tb_prime_checker_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/prime_checker_seq.sv
// Sequential primality tester: odd trial division with a restoring remainder unit, WIDTH cycles per divisor.
// Optional smallest-factor output is enabled by defining PRIME_FACTOR_EN.
module prime_checker_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic             is_prime
`ifdef PRIME_FACTOR_EN
    ,
    output logic [WIDTH-1:0] factor
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, CHECK, DIV, NEXT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]     rem_t;
    logic [WIDTH-1:0]   d_nxt;
    logic [2*WIDTH-1:0] d_ext;
    logic [2*WIDTH-1:0] d_sq;
    logic               past_root;

    // The square of the next divisor is formed at double width so the bound
    // stays exact even for n = 2^WIDTH-1.
    always_comb begin
        rem_t     = {r, sh[WIDTH-1]};
        d_nxt     = d + WIDTH'(2);
        d_ext     = {{WIDTH{1'b0}}, d_nxt};
        d_sq      = d_ext * d_ext;
        past_root = d_sq > {{WIDTH{1'b0}}, n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            n        <= '0;
            d        <= '0;
            sh       <= '0;
            r        <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            is_prime <= 1'b0;
`ifdef PRIME_FACTOR_EN
            factor   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n     <= a;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (n < WIDTH'(2)) begin
                        is_prime <= 1'b0;
`ifdef PRIME_FACTOR_EN
                        factor   <= '0;
`endif
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (n < WIDTH'(4)) begin
                        is_prime <= 1'b1;
`ifdef PRIME_FACTOR_EN
                        factor   <= '0;
`endif
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (!n[0]) begin
                        is_prime <= 1'b0;
`ifdef PRIME_FACTOR_EN
                        factor   <= WIDTH'(2);
`endif
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (n < WIDTH'(9)) begin
                        is_prime <= 1'b1;
`ifdef PRIME_FACTOR_EN
                        factor   <= '0;
`endif
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        d     <= WIDTH'(3);
                        sh    <= n;
                        r     <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    // The partial remainder never reaches d, so the low WIDTH bits suffice.
                    if (rem_t >= {1'b0, d}) begin
                        r <= rem_t[WIDTH-1:0] - d;
                    end else begin
                        r <= rem_t[WIDTH-1:0];
                    end
                    sh  <= sh << 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (r == '0) begin
                        is_prime <= 1'b0;
`ifdef PRIME_FACTOR_EN
                        factor   <= d;
`endif
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (past_root) begin
                        is_prime <= 1'b1;
`ifdef PRIME_FACTOR_EN
                        factor   <= '0;
`endif
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        d     <= d_nxt;
                        sh    <= n;
                        r     <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_checker_seq.sv
// Directed bench for prime_checker_seq at WIDTH=8 and WIDTH=16.
module tb_prime_checker_seq;

    logic        clk;
    logic        rst_n;
    logic        start8, start16;
    logic [7:0]  a8;
    logic [15:0] a16;
    logic        busy8, done8, prime8;
    logic        busy16, done16, prime16;
`ifdef PRIME_FACTOR_EN
    logic [7:0]  factor8;
    logic [15:0] factor16;
`endif

    int checks = 0;
    int errors = 0;

    prime_checker_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8),
        .busy(busy8), .done(done8), .is_prime(prime8)
`ifdef PRIME_FACTOR_EN
        , .factor(factor8)
`endif
    );

    prime_checker_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16),
        .busy(busy16), .done(done16), .is_prime(prime16)
`ifdef PRIME_FACTOR_EN
        , .factor(factor16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sel_done(input bit wide);
        return wide ? done16 : done8;
    endfunction

    function automatic logic sel_busy(input bit wide);
        return wide ? busy16 : busy8;
    endfunction

    // Counts edges after the current one until done is seen; 0 means timeout.
    task automatic wait_done(input bit wide, output int lat);
        lat = 0;
        for (int k = 1; k <= 3000; k++) begin
            @(posedge clk);
            #1;
            if (sel_done(wide)) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run(input bit wide, input int val, input int exp_lat,
                       input int exp_prime, input int exp_fac, input string tag);
        int lat;
        @(negedge clk);
        if (wide) begin start16 = 1'b1; a16 = 16'(val); end
        else      begin start8  = 1'b1; a8  = 8'(val);  end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start16 = 1'b0;
        check({tag, "_busy_acc"}, 32'(sel_busy(wide)), 1);
        wait_done(wide, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_prime"}, 32'(wide ? prime16 : prime8), exp_prime);
`ifdef PRIME_FACTOR_EN
        check({tag, "_factor"}, wide ? 32'(factor16) : 32'(factor8), exp_fac);
`endif
        check({tag, "_busy_done"}, 32'(sel_busy(wide)), 1);
        @(posedge clk);
        #1;
        check({tag, "_busy_end"}, 32'(sel_busy(wide)), 0);
        check({tag, "_done_end"}, 32'(sel_done(wide)), 0);
    endtask

    int sweep_prime [16] = '{0,0,1,1,0,1,0,1,0,0,0,1,0,1,0,0};
    int sweep_lat   [16] = '{1,1,1,1,1,1,1,1,1,10,1,10,1,10,1,10};
    int sweep_fac   [16] = '{0,0,0,0,2,0,2,0,2,3,2,0,2,0,2,3};

    initial begin
        int lat;
        int ndone;
        rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0; a8 = '0; a16 = '0;
        #12;
        check("rst_busy", 32'(busy8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_prime", 32'(prime8), 0);
`ifdef PRIME_FACTOR_EN
        check("rst_factor", 32'(factor8), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 16; v++) begin
            run(1'b0, v, sweep_lat[v], sweep_prime[v], sweep_fac[v], $sformatf("sweep%0d", v));
        end
        run(1'b0, 25, 19, 0, 5, "a25");
        run(1'b0, 251, 64, 1, 0, "a251");
        run(1'b0, 255, 10, 0, 3, "a255");

        // start held plus an extra pulse, operand wiggled while busy
        @(negedge clk);
        a8 = 8'd9;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0;
        for (int k = 1; k <= 11; k++) begin
            if (k == 2) start8 = 1'b0;
            if (k == 3) start8 = 1'b1;
            a8 = 8'(k * 37);
            @(posedge clk);
            #1;
            if (done8) begin
                ndone++;
                check("held_lat", k, 10);
                check("held_prime", 32'(prime8), 0);
            end
        end
        check("held_ndone", ndone, 1);
        check("held_busy_idle", 32'(busy8), 0);
        a8 = 8'd13;
        @(posedge clk);
        #1;
        check("held_reaccept", 32'(busy8), 1);
        start8 = 1'b0;
        a8 = 8'd8;
        wait_done(1'b0, lat);
        check("held2_lat", lat, 10);
        check("held2_prime", 32'(prime8), 1);
        @(posedge clk);
        #1;

        // reset in the middle of a long check
        @(negedge clk);
        a8 = 8'd251;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy8), 0);
        check("mid_rst_done", 32'(done8), 0);
        check("mid_rst_prime", 32'(prime8), 0);
        ndone = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (done8) ndone++;
        end
        check("mid_rst_nodone", ndone, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 13, 10, 1, 0, "after_rst13");

        run(1'b1, 65521, 2160, 1, 0, "w16_65521");
        run(1'b1, 65535, 18, 0, 3, "w16_65535");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
